// File: rtl/dcmem_store_buf.sv
// -----------------------------------------------------------------------------
// dcmem_store_buf
//
// Write-back store buffer that sits between the CPU load/store path and the
// dcmem data memory. CPU stores are queued in a small in-order circular FIFO
// and drained into dcmem one entry per cycle whenever the CPU is not loading.
// Loads are answered combinationally, either from the youngest buffered
// store to the same address or from dcmem. The block owns the single dcmem
// port (MemWEn / addr / dataw).
//
// Optional feature (compile-time macro DCMEM_SB_COALESCE_EN):
//   When defined, a store whose address equals the youngest entry's address
//   overwrites that entry's data instead of allocating a new one, and is
//   accepted even when the buffer is full. This is suppressed when the
//   youngest entry is also the head and is being written to dcmem this cycle;
//   such a store allocates normally. When undefined, every accepted store
//   allocates and reaches dcmem exactly once, in program order.
//
// Parameters:
//   MEM_ADDR_WIDTH  dcmem address width
//   MEM_DATA_WIDTH  data width
//   SB_DEPTH        number of buffer entries (power of two, >= 2)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   st_valid/st_ready          store handshake; push on st_valid && st_ready
//   st_addr, st_data           store address/data
//   ld_req, ld_addr            CPU load this cycle (claims the dcmem port)
//   ld_data, ld_hit            load result (combinational), served-from-buffer
//   flush, flush_done          fence request, one-cycle completion pulse
//   sb_count                   occupied entries
//   mem_wen, mem_addr,
//   mem_wdata, mem_rdata       dcmem port
// -----------------------------------------------------------------------------
module dcmem_store_buf #(
  parameter int MEM_ADDR_WIDTH = 5,
  parameter int MEM_DATA_WIDTH = 16,
  parameter int SB_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        st_valid,
  output logic                        st_ready,
  input  logic [MEM_ADDR_WIDTH-1:0]   st_addr,
  input  logic [MEM_DATA_WIDTH-1:0]   st_data,
  input  logic                        ld_req,
  input  logic [MEM_ADDR_WIDTH-1:0]   ld_addr,
  output logic [MEM_DATA_WIDTH-1:0]   ld_data,
  output logic                        ld_hit,
  input  logic                        flush,
  output logic                        flush_done,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        mem_wen,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
  output logic [MEM_DATA_WIDTH-1:0]   mem_wdata,
  input  logic [MEM_DATA_WIDTH-1:0]   mem_rdata
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Entry storage; contents are don't-care out of reset, validity comes
  // from head/count.
  logic [MEM_ADDR_WIDTH-1:0] addr_mem_r [SB_DEPTH];
  logic [MEM_DATA_WIDTH-1:0] data_mem_r [SB_DEPTH];

  logic [PTR_W-1:0]          head_r;
  logic [PTR_W-1:0]          tail_r;
  logic [CNT_W-1:0]          count_r;
  state_t                    state_r;
  logic                      flush_done_r;

  logic                      empty_s;
  logic                      full_s;
  logic                      pop_s;
  logic                      push_s;
  logic                      coal_s;
  logic                      alloc_s;
  logic [CNT_W-1:0]          count_nxt_s;
  state_t                    state_nxt_s;
  logic                      done_nxt_s;
  logic                      fwd_hit_s;
  logic [MEM_DATA_WIDTH-1:0] fwd_data_s;

  // Occupancy status; full is taken from the registered count so a store is
  // refused when full even if the head drains in the same cycle.
  always_comb begin
    empty_s = (count_r == {CNT_W{1'b0}});
    full_s  = (count_r == CNT_W'(SB_DEPTH));
  end

  // A load owns the dcmem port; the head drains only on load-free cycles.
  always_comb begin
    pop_s = rst_n && !empty_s && !ld_req;
  end

`ifdef DCMEM_SB_COALESCE_EN
  logic [PTR_W-1:0] youngest_s;

  // Coalesce into the youngest entry unless that entry is the head and is
  // leaving for dcmem this cycle (it would otherwise lose the new data).
  always_comb begin
    youngest_s = tail_r - PTR_W'(1);
    if (!empty_s && (addr_mem_r[youngest_s] == st_addr) &&
        !((count_r == CNT_W'(1)) && pop_s)) begin
      coal_s = 1'b1;
    end else begin
      coal_s = 1'b0;
    end
  end
`else
  // Coalescing is compiled out: every accepted store allocates.
  always_comb begin
    coal_s = 1'b0;
  end
`endif

  // Store handshake: only in RUN, and a coalescing store needs no free slot.
  always_comb begin
    st_ready = rst_n && (state_r == RUN) && (!full_s || coal_s);
    push_s   = st_valid && st_ready;
    alloc_s  = push_s && !coal_s;
  end

  // Occupancy next-state; a simultaneous allocate and pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    if (alloc_s && !pop_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (!alloc_s && pop_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // dcmem port mux: head entry while draining, otherwise the load address.
  always_comb begin
    mem_wen = pop_s;
    if (pop_s) begin
      mem_addr  = addr_mem_r[head_r];
      mem_wdata = data_mem_r[head_r];
    end else begin
      mem_addr  = ld_addr;
      mem_wdata = {MEM_DATA_WIDTH{1'b0}};
    end
  end

  // Store-to-load forwarding: walk valid entries oldest to youngest so the
  // last match (youngest) wins. The head is still valid during its drain
  // cycle, and a store being accepted this cycle is not yet visible.
  always_comb begin
    logic [PTR_W-1:0] idx_v;
    idx_v      = {PTR_W{1'b0}};
    fwd_hit_s  = 1'b0;
    fwd_data_s = mem_rdata;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx_v = head_r + PTR_W'(i);
      if ((CNT_W'(i) < count_r) && (addr_mem_r[idx_v] == ld_addr)) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = data_mem_r[idx_v];
      end else begin
        // invalid slot or different address: keep the current answer
      end
    end
  end

  // Load result outputs.
  always_comb begin
    ld_data = fwd_data_s;
    ld_hit  = rst_n && fwd_hit_s;
  end

  // Flush FSM next-state; completion is flagged for the cycle after the
  // buffer becomes empty (or immediately after a flush of an empty buffer).
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      RUN: begin
        if (flush) begin
          if (empty_s) begin
            done_nxt_s = 1'b1;
          end else begin
            state_nxt_s = FLUSH;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH: begin
        if (count_nxt_s == {CNT_W{1'b0}}) begin
          state_nxt_s = RUN;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: begin
        state_nxt_s = RUN;
        done_nxt_s  = 1'b0;
      end
    endcase
  end

  // Pointer, occupancy and FSM registers; reset discards pending stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r       <= {PTR_W{1'b0}};
      tail_r       <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      state_r      <= RUN;
      flush_done_r <= 1'b0;
    end else begin
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      if (alloc_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      count_r      <= count_nxt_s;
      state_r      <= state_nxt_s;
      flush_done_r <= done_nxt_s;
    end
  end

  // Entry storage writes: allocate at the tail, or merge into the youngest.
  always_ff @(posedge clk) begin
    if (alloc_s) begin
      addr_mem_r[tail_r] <= st_addr;
      data_mem_r[tail_r] <= st_data;
    end
`ifdef DCMEM_SB_COALESCE_EN
    else if (push_s && coal_s) begin
      data_mem_r[youngest_s] <= st_data;
    end
`endif
  end

  // Registered status outputs.
  always_comb begin
    sb_count   = count_r;
    flush_done = flush_done_r;
  end

endmodule
